exe_mem_stage: RTL and testbench
================================

Name: exe_mem_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the 64-bit ALU (add/sub/and/xor units).
- Captures the ALU result and overflow flag, maintains the architectural condition-code register (ZF/SF/OF), and evaluates the branch/cmov condition.
- Presents a registered bundle to the memory stage under a valid/ready handshake, with stall and bubble support.

Parameters:
- W, 64, datapath width of valE/valA.
- RNONE, 4'hF, register ID meaning "no destination".
- NOP_ICODE, 4'h1, icode loaded on reset or bubble.
- OPQ_ICODE, 4'h6, icode of ALU ops that update CC.
- CMOV_ICODE, 4'h2, icode of conditional move.
- JXX_ICODE, 4'h7, icode of conditional jump.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- e_valid  in  1  execute bundle valid.
- e_ready  out  1  stage can accept the bundle this cycle.
- e_bubble  in  1  squash: load a NOP instead of the bundle.
- e_cc_en  in  1  permit CC update, deasserted on downstream exception.
- e_icode  in  4  instruction code.
- e_ifun  in  4  function / condition code.
- e_valE  in  W  ALU result.
- e_of  in  1  ALU overflow flag (0 for bitwise ops).
- e_valA  in  W  pass-through operand.
- e_dstE  in  4  ALU-result destination register.
- e_dstM  in  4  memory-result destination register.
- m_ready  in  1  memory stage accepts.
- m_valid  out  1  output bundle valid.
- m_icode  out  4  registered icode.
- m_cnd  out  1  registered condition outcome.
- m_valE  out  W  registered result.
- m_valA  out  W  registered valA.
- m_dstE  out  4  registered dstE (RNONE if cmov not taken).
- m_dstM  out  4  registered dstM.
- cc_zf  out  1  condition-code zero flag.
- cc_sf  out  1  condition-code sign flag.
- cc_of  out  1  condition-code overflow flag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - m_valid=0, m_icode=NOP_ICODE, m_cnd=0.
  - m_valE=0, m_valA=0, m_dstE=m_dstM=RNONE.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - Reset overrides every other input, including mid-transfer.
- Handshake:
  - e_ready = ~m_valid | m_ready (combinational, no bubble cycle).
  - Accept when e_valid & e_ready; latency is 1 cycle to m_valid.
  - While m_valid & ~m_ready, all m_* outputs and the CC hold stable.
  - When e_ready=1 and e_valid=0, m_valid clears at the edge; m_* data may hold.
- CC update:
  - On accept with e_icode==OPQ_ICODE, e_cc_en=1 and e_bubble=0:
    - ZF = (e_valE==0)
    - SF = e_valE[W-1]
    - OF = e_of
  - Otherwise the CC is unchanged.
- Condition:
  - Evaluated combinationally from the current CC, i.e. before this cycle's update, and registered into m_cnd on accept.
  - ifun mapping:
    - 0: 1
    - 1: (SF^OF)|ZF
    - 2: SF^OF
    - 3: ZF
    - 4: ~ZF
    - 5: ~(SF^OF)
    - 6: ~(SF^OF)&~ZF
    - 7–15: 0
  - Non-CMOV/JXX icodes register m_cnd=1.
  - CMOV with cnd=0 registers m_dstE=RNONE.
- Bubble:
  - e_bubble with e_ready=1 loads the reset bundle (NOP, RNONE, zeros), sets m_valid=0 and leaves the CC untouched, regardless of e_valid.
  - e_bubble while stalled (e_ready=0) is ignored; the held bundle is kept.
- Simultaneous events:
  - OPq accept and a stalled output cannot coincide, since e_ready=0 blocks accept.
  - Back-to-back OPq accepts update the CC on each edge; the second instruction's cnd sees the first instruction's flags.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> m_valid=0, m_icode=1, m_dstE=F, cc_zf=1, cc_sf=0, cc_of=0.
- OPq xor: icode=6, valE=0, of=0, accepted -> next cycle m_valid=1, m_valE=0, cc_zf=1, cc_sf=0; then valE=0x8000000000000000 -> cc_zf=0, cc_sf=1.
- Conditional move: CC set to ZF=1; cmov ifun=4 (ne), dstE=3 -> m_cnd=0, m_dstE=F; repeat with ifun=3 -> m_cnd=1, m_dstE=3.
- Stall: m_ready=0 with m_valid=1 for 3 cycles while e_valid=1, icode=6, valE=5 -> e_ready=0, outputs and CC frozen; release m_ready -> bundle accepted, cc_zf=0 one cycle later.
- Bubble/cc_en: e_bubble=1 with OPq valE=0 -> m_valid=0, m_icode=1, CC unchanged; OPq with e_cc_en=0 -> m_valid=1, CC unchanged.
- Reset mid-stall: m_valid=1, m_ready=0, rst_n=0 one cycle -> m_valid=0 and all reset values restored.

Source files
------------

// File: rtl/exe_mem_if.sv
// Execute-to-memory bundle: execute-side inputs, memory-side outputs and the
// architectural condition codes exported by the stage.
interface exe_mem_if #(
    parameter int W = 64
);
    logic         e_valid;
    logic         e_ready;
    logic         e_bubble;
    logic         e_cc_en;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] e_valE;
    logic         e_of;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic         m_ready;
    logic         m_valid;
    logic [3:0]   m_icode;
    logic         m_cnd;
    logic [W-1:0] m_valE;
    logic [W-1:0] m_valA;
    logic [3:0]   m_dstE;
    logic [3:0]   m_dstM;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    // Upstream driver / downstream consumer side (testbench or neighbours).
    modport master (
        output e_valid, e_bubble, e_cc_en, e_icode, e_ifun, e_valE, e_of,
               e_valA, e_dstE, e_dstM, m_ready,
        input  e_ready, m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE,
               m_dstM, cc_zf, cc_sf, cc_of
    );

    // The pipeline stage itself.
    modport slave (
        input  e_valid, e_bubble, e_cc_en, e_icode, e_ifun, e_valE, e_of,
               e_valA, e_dstE, e_dstM, m_ready,
        output e_ready, m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE,
               m_dstM, cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/exe_mem_stage.sv
// Execute-to-memory pipeline register. Captures the ALU result, owns the
// ZF/SF/OF condition codes, evaluates the branch/cmov condition against the
// flags as they stood before this cycle's update, and hands the bundle to the
// memory stage under valid/ready with stall and bubble support.
module exe_mem_stage #(
    parameter int         W          = 64,
    parameter logic [3:0] RNONE      = 4'hF,
    parameter logic [3:0] NOP_ICODE  = 4'h1,
    parameter logic [3:0] OPQ_ICODE  = 4'h6,
    parameter logic [3:0] CMOV_ICODE = 4'h2,
    parameter logic [3:0] JXX_ICODE  = 4'h7
) (
    input  logic      clk,
    input  logic      rst_n,
    exe_mem_if.slave  bus
);

    logic         m_valid_q, m_valid_d;
    logic [3:0]   m_icode_q, m_icode_d;
    logic         m_cnd_q,   m_cnd_d;
    logic [W-1:0] m_valE_q,  m_valE_d;
    logic [W-1:0] m_valA_q,  m_valA_d;
    logic [3:0]   m_dstE_q,  m_dstE_d;
    logic [3:0]   m_dstM_q,  m_dstM_d;
    logic         cc_zf_q,   cc_zf_d;
    logic         cc_sf_q,   cc_sf_d;
    logic         cc_of_q,   cc_of_d;

    logic         e_ready;
    logic         cond;
    logic         lt;

    // The register can take a new bundle whenever it is empty or being drained.
    assign e_ready = ~m_valid_q | bus.m_ready;

    // Condition outcome from the flags currently held (pre-update).
    always_comb begin
        lt   = cc_sf_q ^ cc_of_q;
        cond = 1'b0;
        case (bus.e_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = lt | cc_zf_q;
            4'd2:    cond = lt;
            4'd3:    cond = cc_zf_q;
            4'd4:    cond = ~cc_zf_q;
            4'd5:    cond = ~lt;
            4'd6:    cond = ~lt & ~cc_zf_q;
            default: cond = 1'b0;
        endcase
    end

    // Next-state: hold by default; load bubble, bundle or empty slot when ready.
    always_comb begin
        m_valid_d = m_valid_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_valE_d  = m_valE_q;
        m_valA_d  = m_valA_q;
        m_dstE_d  = m_dstE_q;
        m_dstM_d  = m_dstM_q;
        cc_zf_d   = cc_zf_q;
        cc_sf_d   = cc_sf_q;
        cc_of_d   = cc_of_q;

        if (e_ready) begin
            if (bus.e_bubble) begin
                // Squash: insert the same NOP bundle that reset produces.
                m_valid_d = 1'b0;
                m_icode_d = NOP_ICODE;
                m_cnd_d   = 1'b0;
                m_valE_d  = '0;
                m_valA_d  = '0;
                m_dstE_d  = RNONE;
                m_dstM_d  = RNONE;
            end else if (bus.e_valid) begin
                m_valid_d = 1'b1;
                m_icode_d = bus.e_icode;
                m_valE_d  = bus.e_valE;
                m_valA_d  = bus.e_valA;
                m_dstM_d  = bus.e_dstM;
                if ((bus.e_icode == CMOV_ICODE) || (bus.e_icode == JXX_ICODE)) begin
                    m_cnd_d = cond;
                end else begin
                    m_cnd_d = 1'b1;
                end
                // An untaken cmov must not write its destination.
                if ((bus.e_icode == CMOV_ICODE) && !cond) begin
                    m_dstE_d = RNONE;
                end else begin
                    m_dstE_d = bus.e_dstE;
                end
                if ((bus.e_icode == OPQ_ICODE) && bus.e_cc_en) begin
                    cc_zf_d = (bus.e_valE == '0);
                    cc_sf_d = bus.e_valE[W-1];
                    cc_of_d = bus.e_of;
                end
            end else begin
                m_valid_d = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset to the NOP bundle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_icode_q <= NOP_ICODE;
            m_cnd_q   <= 1'b0;
            m_valE_q  <= '0;
            m_valA_q  <= '0;
            m_dstE_q  <= RNONE;
            m_dstM_q  <= RNONE;
            cc_zf_q   <= 1'b1;
            cc_sf_q   <= 1'b0;
            cc_of_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_valE_q  <= m_valE_d;
            m_valA_q  <= m_valA_d;
            m_dstE_q  <= m_dstE_d;
            m_dstM_q  <= m_dstM_d;
            cc_zf_q   <= cc_zf_d;
            cc_sf_q   <= cc_sf_d;
            cc_of_q   <= cc_of_d;
        end
    end

    assign bus.e_ready = e_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_icode = m_icode_q;
    assign bus.m_cnd   = m_cnd_q;
    assign bus.m_valE  = m_valE_q;
    assign bus.m_valA  = m_valA_q;
    assign bus.m_dstE  = m_dstE_q;
    assign bus.m_dstM  = m_dstM_q;
    assign bus.cc_zf   = cc_zf_q;
    assign bus.cc_sf   = cc_sf_q;
    assign bus.cc_of   = cc_of_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: the driver predicts each accepted
// bundle from the instruction semantics and queues it; a monitor compares
// whatever the stage presents against the queue head.
module tb_exe_mem_stage;

    localparam int W = 64;

    typedef struct {
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } exp_t;

    logic clk;
    logic rst_n;

    exe_mem_if #(.W(W)) bus ();

    exe_mem_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   checks;
    int   errors;
    exp_t sb_q[$];

    // Reference state: is a bundle held, is it the NOP bundle, current flags.
    bit mdl_valid;
    bit mdl_nop;
    bit mzf, msf, mof;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit cond_of(input logic [3:0] ifn, input bit zf, input bit sf, input bit of_f);
        bit less;
        less = sf ^ of_f;
        case (ifn)
            4'd0:    return 1'b1;          // always
            4'd1:    return less || zf;    // le
            4'd2:    return less;          // l
            4'd3:    return zf;            // e
            4'd4:    return !zf;           // ne
            4'd5:    return !less;         // ge
            4'd6:    return !less && !zf;  // g
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: compare the presented bundle to the queue head; retire on ready.
    always @(negedge clk) begin
        if (rst_n && bus.m_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("mon_unexpected_valid", 64'd1, 64'd0);
            end else begin
                chk("m_icode", bus.m_icode, sb_q[0].icode);
                chk("m_cnd",   bus.m_cnd,   sb_q[0].cnd);
                chk("m_valE",  bus.m_valE,  sb_q[0].valE);
                chk("m_valA",  bus.m_valA,  sb_q[0].valA);
                chk("m_dstE",  bus.m_dstE,  sb_q[0].dstE);
                chk("m_dstM",  bus.m_dstM,  sb_q[0].dstM);
                if (bus.m_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        mdl_valid = 1'b0;
        mdl_nop   = 1'b1;
        mzf = 1'b1; msf = 1'b0; mof = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n        = 1'b0;
        bus.e_valid  = 1'b0;
        bus.e_bubble = 1'b0;
        bus.m_ready  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle: drive inputs, check the stage against the model, advance model.
    task automatic step(input bit v, input bit b, input bit ccen,
                        input logic [3:0] ic, input logic [3:0] ifn,
                        input logic [63:0] ve, input bit ofl, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm, input bit mr);
        bit   exp_ready;
        bit   c;
        exp_t e;
        @(posedge clk); #1;
        bus.e_valid  = v;
        bus.e_bubble = b;
        bus.e_cc_en  = ccen;
        bus.e_icode  = ic;
        bus.e_ifun   = ifn;
        bus.e_valE   = ve;
        bus.e_of     = ofl;
        bus.e_valA   = va;
        bus.e_dstE   = de;
        bus.e_dstM   = dm;
        bus.m_ready  = mr;
        @(negedge clk); #1;
        chk("m_valid", bus.m_valid, mdl_valid);
        chk("cc_zf", bus.cc_zf, mzf);
        chk("cc_sf", bus.cc_sf, msf);
        chk("cc_of", bus.cc_of, mof);
        if (mdl_nop) begin
            chk("nop_icode", bus.m_icode, 4'h1);
            chk("nop_cnd",   bus.m_cnd,   1'b0);
            chk("nop_valE",  bus.m_valE,  64'd0);
            chk("nop_valA",  bus.m_valA,  64'd0);
            chk("nop_dstE",  bus.m_dstE,  4'hF);
            chk("nop_dstM",  bus.m_dstM,  4'hF);
        end
        exp_ready = !mdl_valid || mr;
        chk("e_ready", bus.e_ready, exp_ready);
        if (exp_ready) begin
            if (b) begin
                mdl_valid = 1'b0;
                mdl_nop   = 1'b1;
            end else if (v) begin
                c = cond_of(ifn, mzf, msf, mof);
                e.icode = ic;
                e.cnd   = (ic == 4'h2 || ic == 4'h7) ? c : 1'b1;
                e.valE  = ve;
                e.valA  = va;
                e.dstE  = (ic == 4'h2 && !c) ? 4'hF : de;
                e.dstM  = dm;
                sb_q.push_back(e);
                if (ic == 4'h6 && ccen) begin
                    mzf = (ve == 64'd0);
                    msf = ve[63];
                    mof = ofl;
                end
                mdl_valid = 1'b1;
                mdl_nop   = 1'b0;
            end else begin
                mdl_valid = 1'b0;
                mdl_nop   = 1'b0;
            end
        end
    endtask

    task automatic idle(input bit mr);
        step(1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 64'd0, 1'b0, 64'd0, 4'hF, 4'hF, mr);
    endtask

    function automatic logic [63:0] rnd_val();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return 64'd0;
            1:       return r | 64'h8000_0000_0000_0000;
            default: return r;
        endcase
    endfunction

    function automatic logic [3:0] rnd_icode();
        case ($urandom_range(0, 5))
            0:       return 4'h1;
            1:       return 4'h2;
            2, 3:    return 4'h6;
            4:       return 4'h7;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.e_valid = 1'b0; bus.e_bubble = 1'b0; bus.e_cc_en = 1'b1;
        bus.e_icode = 4'h1; bus.e_ifun = 4'h0; bus.e_valE = '0; bus.e_of = 1'b0;
        bus.e_valA = '0; bus.e_dstE = 4'hF; bus.e_dstM = 4'hF; bus.m_ready = 1'b0;
        model_reset();

        // Reset then idle.
        do_reset(2);
        idle(1'b1);

        // OPq xor producing zero, then a negative result.
        step(1, 0, 1, 4'h6, 4'h3, 64'd0, 0, 64'h11, 4'h2, 4'hF, 1);
        step(1, 0, 1, 4'h6, 4'h3, 64'h8000_0000_0000_0000, 0, 64'h22, 4'h2, 4'hF, 1);
        idle(1'b1);

        // Conditional move with ZF=1: ne not taken, e taken.
        step(1, 0, 1, 4'h6, 4'h0, 64'd0, 0, 64'd0, 4'h1, 4'hF, 1);
        step(1, 0, 1, 4'h2, 4'h4, 64'h55, 0, 64'h55, 4'h3, 4'hF, 1);
        step(1, 0, 1, 4'h2, 4'h3, 64'h66, 0, 64'h66, 4'h3, 4'hF, 1);
        idle(1'b1);

        // Stall for three cycles with an OPq waiting, then release.
        step(1, 0, 1, 4'h6, 4'h0, 64'd0, 0, 64'h7, 4'h4, 4'hF, 1);
        repeat (3) step(1, 0, 1, 4'h6, 4'h0, 64'd5, 0, 64'h8, 4'h5, 4'hF, 0);
        step(1, 0, 1, 4'h6, 4'h0, 64'd5, 0, 64'h8, 4'h5, 4'hF, 1);
        idle(1'b1);
        idle(1'b1);

        // Bubble over an OPq, then OPq with CC update disabled.
        step(1, 1, 1, 4'h6, 4'h0, 64'd0, 0, 64'h9, 4'h6, 4'hF, 1);
        step(1, 0, 0, 4'h6, 4'h0, 64'd0, 1, 64'ha, 4'h6, 4'hF, 1);
        idle(1'b1);
        // Bubble while stalled is ignored.
        step(1, 0, 1, 4'h6, 4'h0, 64'h8000_0000_0000_0001, 1, 64'hb, 4'h7, 4'h8, 0);
        step(1, 1, 1, 4'h6, 4'h0, 64'd0, 0, 64'hc, 4'h7, 4'h8, 0);
        idle(1'b1);

        // Reset while stalled.
        step(1, 0, 1, 4'h6, 4'h0, 64'd3, 0, 64'hd, 4'h9, 4'hA, 0);
        step(1, 0, 1, 4'h6, 4'h0, 64'd4, 0, 64'he, 4'h9, 4'hA, 0);
        do_reset(1);
        idle(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 7) != 0, rnd_icode(),
                     ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
                     rnd_val(), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3) != 0);
            end
        end

        // Drain and confirm every predicted bundle was delivered.
        repeat (3) idle(1'b1);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
